bcd_display_driver: RTL and testbench

//   Downstream of the calculator core. Accepts a 32-bit binary result plus an error flag.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/dabble_step.sv | 30 +++
 rtl/bcd_display_driver.sv | 210 +++++++++++++++++++++
 tb/tb_bcd_display_driver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator core and its display back end.
// Contents: command codes, status encoding, driver FSM states, special digit
// codes, the error sentinel value, internal BCD capacity and the add-3 helper
// used by the double-dabble step.
package calc_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ADD = 3'd1,
        CMD_SUB = 3'd2,
        CMD_MUL = 3'd3,
        CMD_DIV = 3'd4,
        CMD_CLR = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_OK    = 2'b10,
        ST_ERROR = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CONV = 2'b01,
        S_EMIT = 2'b10
    } state_t;

    localparam logic [3:0]  DIGIT_ERR    = 4'hE;
    localparam logic [3:0]  DIGIT_BLANK  = 4'hF;
    localparam logic [31:0] ERR_SENTINEL = 32'hFFFF_FFFF;

    // Enough decimal digits for any 32-bit value (4294967295 has 10).
    localparam int BCD_CAP = 10;

    // Double-dabble correction: a digit >= 5 would exceed 9 after the shift.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/dabble_step.sv
// One combinational double-dabble iteration over BCD_CAP digits.
// Ports:
//   bcd_in    : current BCD accumulator (digit 0 in bits [3:0])
//   msb_in    : next binary bit shifted in (MSB of the binary shift register)
//   bcd_out   : accumulator after add-3 correction and left shift
//   carry_out : bit shifted out of the top digit (nonzero means overflow)
module dabble_step
    import calc_pkg::*;
#(
    parameter int CAP = BCD_CAP
) (
    input  logic [4*CAP-1:0] bcd_in,
    input  logic             msb_in,
    output logic [4*CAP-1:0] bcd_out,
    output logic             carry_out
);

    logic [4*CAP-1:0] adj_s;

    // Apply add-3 to every digit, then shift the whole accumulator left by one.
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < CAP; i++) begin
            adj_s[4*i +: 4] = add3_if_ge5(bcd_in[4*i +: 4]);
        end
        bcd_out   = {adj_s[4*CAP-2:0], msb_in};
        carry_out = adj_s[4*CAP-1];
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD display driver. Accepts a binary result plus error flag,
// converts it with serial double-dabble (one iteration per clock) and streams
// NDIGITS digits, least significant first, over a valid/ready interface.
// Ports:
//   clock, reset (sync, active high), clr (sync abort, same as reset)
//   in_value/in_error/in_valid/in_ready : input handshake
//   data/position/digit_valid/disp_ready: digit stream to the display mux
//   status                              : 00 idle, 01 busy, 10 ok, 11 error
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (shown as 4'hF) in normal mode; position 0 always shows its digit.
module bcd_display_driver
    import calc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NDIGITS = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           in_value,
    input  logic                       in_error,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [3:0]                 data,
    output logic [$clog2(NDIGITS)-1:0] position,
    output logic                       digit_valid,
    input  logic                       disp_ready,
    output logic [1:0]                 status
);

    localparam int POS_W  = $clog2(NDIGITS);
    localparam int ITER_W = $clog2(WIDTH);
    localparam logic [POS_W-1:0]  LAST_K    = POS_W'(NDIGITS - 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [4*BCD_CAP-1:0] bcd_q, bcd_d;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic [POS_W-1:0]     k_q, k_d;
    logic                 err_q, err_d;
    status_t              status_q, status_d;
    logic [3:0]           data_q, data_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic                 dv_q, dv_d;

    logic [4*BCD_CAP-1:0] step_bcd_s;
    logic                 step_carry_s;
    logic                 ovf_s;
    logic [POS_W-1:0]     emit_idx_s;
    logic                 blank_s;
    logic [3:0]           code_s;

    dabble_step #(.CAP(BCD_CAP)) u_step (
        .bcd_in    (bcd_q),
        .msb_in    (bin_q[WIDTH-1]),
        .bcd_out   (step_bcd_s),
        .carry_out (step_carry_s)
    );

    // Result does not fit the display: anything landed above the shown digits.
    assign ovf_s = step_carry_s | (|step_bcd_s[4*BCD_CAP-1:4*NDIGITS]);

    // Digit to present next: the current index on the first EMIT cycle,
    // the following index once the current digit is already on the bus.
    assign emit_idx_s = dv_q ? (k_q + POS_W'(1)) : k_q;

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero_s;

    // A digit is blank when it and every digit above it are zero (never digit 0).
    always_comb begin
        upper_zero_s = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            upper_zero_s = upper_zero_s &
                           ~((POS_W'(i) >= emit_idx_s) & (bcd_q[4*i +: 4] != 4'd0));
        end
        blank_s = upper_zero_s & (emit_idx_s != '0);
    end
`else
    assign blank_s = 1'b0;
`endif

    // Select the digit code for the next presented position.
    always_comb begin
        if (err_q) begin
            code_s = DIGIT_ERR;
        end else if (blank_s) begin
            code_s = DIGIT_BLANK;
        end else begin
            code_s = bcd_q[4*emit_idx_s +: 4];
        end
    end

    // Next-state and output logic for the IDLE -> CONV -> EMIT sequence.
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        k_d      = k_q;
        err_d    = err_q;
        status_d = status_q;
        data_d   = data_q;
        pos_d    = pos_q;
        dv_d     = dv_q;
        if (clr) begin
            state_d  = S_IDLE;
            bin_d    = '0;
            bcd_d    = '0;
            iter_d   = '0;
            k_d      = '0;
            err_d    = 1'b0;
            status_d = ST_IDLE;
            data_d   = 4'd0;
            pos_d    = '0;
            dv_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        status_d = ST_BUSY;
                        bcd_d    = '0;
                        iter_d   = '0;
                        k_d      = '0;
                        if (in_error || (in_value == WIDTH'(ERR_SENTINEL))) begin
                            err_d   = 1'b1;
                            bin_d   = '0;
                            state_d = S_EMIT;
                        end else begin
                            err_d   = 1'b0;
                            bin_d   = in_value;
                            state_d = S_CONV;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CONV: begin
                    bcd_d  = step_bcd_s;
                    bin_d  = {bin_q[WIDTH-2:0], 1'b0};
                    iter_d = iter_q + ITER_W'(1);
                    if (iter_q == LAST_ITER) begin
                        err_d   = ovf_s;
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_CONV;
                    end
                end
                S_EMIT: begin
                    if (!dv_q) begin
                        dv_d   = 1'b1;
                        data_d = code_s;
                        pos_d  = k_q;
                    end else if (disp_ready) begin
                        if (k_q == LAST_K) begin
                            dv_d     = 1'b0;
                            state_d  = S_IDLE;
                            status_d = err_q ? ST_ERROR : ST_OK;
                        end else begin
                            k_d    = emit_idx_s;
                            data_d = code_s;
                            pos_d  = emit_idx_s;
                        end
                    end else begin
                        dv_d = dv_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    dv_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            k_q      <= '0;
            err_q    <= 1'b0;
            status_q <= ST_IDLE;
            data_q   <= 4'd0;
            pos_q    <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            k_q      <= k_d;
            err_q    <= err_d;
            status_q <= status_d;
            data_q   <= data_d;
            pos_q    <= pos_d;
            dv_q     <= dv_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE) && !clr;
    assign data        = data_q;
    assign position    = pos_q;
    assign digit_valid = dv_q;
    assign status      = status_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: the driver pushes the expected
// digit stream (computed with decimal arithmetic) on each accepted input and
// a negedge monitor compares every presented digit against the queue front.
module tb_bcd_display_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] in_value = 32'd0;
    logic        in_error = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  data;
    logic [2:0]  position;
    logic        digit_valid;
    logic        disp_ready = 1'b1;
    logic [1:0]  status;

    bcd_display_driver dut (
        .clock       (clock),
        .reset       (reset),
        .clr         (clr),
        .in_value    (in_value),
        .in_error    (in_error),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data        (data),
        .position    (position),
        .digit_valid (digit_valid),
        .disp_ready  (disp_ready),
        .status      (status)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] data;
        logic [2:0] pos;
        bit         last;
        logic [1:0] exp_status;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         lat_pending = 0;
    int         lat_cyc = 0;
    bit         st_pending = 0;
    logic [1:0] st_exp = 2'b00;
    int         ready_mode = 0;
    int         stall_cnt = 0;
    exp_t       mon_e;

    always @(posedge clock) cyc = cyc + 1;

    // Display-side ready generation.
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0: disp_ready = 1'b1;
            1: disp_ready = 1'($urandom_range(0, 1));
            2: disp_ready = 1'b0;
            3: begin
                if (digit_valid && position == 3'd1 && stall_cnt < 5) begin
                    disp_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    disp_ready = 1'b1;
                end
            end
            default: disp_ready = 1'b1;
        endcase
    end

    // Monitor: compare presented digits with the expected queue front.
    always @(negedge clock) begin
        if (st_pending) begin
            n_chk++;
            if (status !== st_exp) begin
                n_fail++;
                $display("FAIL final_status: got %b expected %b", status, st_exp);
            end
            st_pending = 0;
        end
        if (!reset && digit_valid) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_digit: data %h pos %0d with nothing expected", data, position);
            end else begin
                mon_e = exp_q[0];
                if (data !== mon_e.data || position !== mon_e.pos) begin
                    n_fail++;
                    $display("FAIL digit: got data %h pos %0d expected data %h pos %0d",
                             data, position, mon_e.data, mon_e.pos);
                end
                if (lat_pending) begin
                    n_chk++;
                    if (cyc != lat_cyc) begin
                        n_fail++;
                        $display("FAIL first_digit_latency: got cycle %0d expected %0d", cyc, lat_cyc);
                    end
                    lat_pending = 0;
                end
                if (disp_ready) begin
                    void'(exp_q.pop_front());
                    if (mon_e.last) begin
                        st_pending = 1;
                        st_exp     = mon_e.exp_status;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference model: decimal digits, overflow and error rules.
    task automatic push_expected(input logic [31:0] v, input logic e, input int accept_cyc);
        logic [63:0] v64;
        logic [63:0] p;
        bit          hard_err;
        bit          err;
        exp_t        ent;
        v64      = {32'd0, v};
        hard_err = e || (v == 32'hFFFF_FFFF);
        err      = hard_err || (v64 >= 64'd100_000_000);
        p        = 64'd1;
        for (int k = 0; k < 8; k++) begin
            ent.data = err ? 4'hE : 4'((v64 / p) % 64'd10);
`ifdef LEADING_ZERO_BLANK_EN
            if (!err && k > 0 && v64 < p) ent.data = 4'hF;
`endif
            ent.pos        = 3'(k);
            ent.last       = (k == 7);
            ent.exp_status = err ? 2'b11 : 2'b10;
            exp_q.push_back(ent);
            p = p * 64'd10;
        end
        lat_cyc     = accept_cyc + (hard_err ? 1 : 33);
        lat_pending = 1;
    endtask

    task automatic send(input logic [31:0] v, input logic e);
        @(posedge clock);
        #1;
        in_value = v;
        in_error = e;
        in_valid = 1'b1;
        @(negedge clock);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        push_expected(v, e, cyc + 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_value = $urandom;
        in_error = 1'b0;
        @(negedge clock);
        check("status_busy", {30'd0, status}, 32'd1);
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || st_pending) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0 || st_pending) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d digits outstanding", exp_q.size());
            exp_q.delete();
            st_pending  = 0;
            lat_pending = 0;
        end
        @(negedge clock);
    endtask

    task automatic flush();
        exp_q.delete();
        st_pending  = 0;
        lat_pending = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] v;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_data", {28'd0, data}, 32'd0);
        check("reset_position", {29'd0, position}, 32'd0);
        check("reset_valid", {31'd0, digit_valid}, 32'd0);
        check("reset_status", {30'd0, status}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        send(32'd1234, 1'b0);          wait_done(300);
        send(32'd99_999_999, 1'b0);    wait_done(300);
        send(32'd100_000_000, 1'b0);   wait_done(300);
        send(32'hFFFF_FFFF, 1'b0);     wait_done(300);
        send($urandom, 1'b1);          wait_done(300);

        // Backpressure hold at position 1.
        stall_cnt  = 0;
        ready_mode = 3;
        send(32'd56, 1'b0);            wait_done(300);
        check("stall_cycles", stall_cnt, 32'd5);
        ready_mode = 0;

        // Abort mid-conversion.
        send(32'd12_345_678, 1'b0);
        repeat (9) @(posedge clock);
        #1 clr = 1'b1;
        @(negedge clock);
        check("in_ready_during_clr", {31'd0, in_ready}, 32'd0);
        @(posedge clock);
        #1 clr = 1'b0;
        flush();
        @(negedge clock);
        check("clr_status", {30'd0, status}, 32'd0);
        check("clr_in_ready", {31'd0, in_ready}, 32'd1);
        check("clr_valid", {31'd0, digit_valid}, 32'd0);

        // clr together with in_valid: nothing accepted.
        @(posedge clock);
        #1 clr = 1'b1; in_valid = 1'b1; in_value = 32'd5;
        @(negedge clock);
        check("clr_vs_valid_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock);
        #1 clr = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check("clr_vs_valid_status", {30'd0, status}, 32'd0);
        repeat (40) @(negedge clock);

        send(32'd7, 1'b0);             wait_done(300);

        // Abort mid-emission with the display stalled.
        ready_mode = 2;
        send(32'd1234, 1'b0);
        n = 0;
        while (!digit_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("stalled_digit_seen", {31'd0, digit_valid}, 32'd1);
        @(posedge clock);
        #1 clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
        flush();
        ready_mode = 0;
        @(negedge clock);
        check("clr_emit_valid", {31'd0, digit_valid}, 32'd0);
        check("clr_emit_status", {30'd0, status}, 32'd0);

        send(32'd0, 1'b0);             wait_done(300);

        // Randomized values with random display backpressure.
        ready_mode = 1;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom_range(0, 99_999_999);
                2: v = $urandom_range(0, 999);
                default: v = ($urandom_range(0, 1) == 0) ? 32'd99_999_999 : 32'd100_000_000;
            endcase
            send(v, ($urandom_range(0, 7) == 0));
            wait_done(400);
        end
        ready_mode = 0;
        repeat (5) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
